// File: rtl/tpu_act_stream_buffer.sv
// Double-buffered activation buffer: the loader fills the shadow set while the active
// set streams rows (strided, wrapping, lane-masked) to a systolic array row input.
module tpu_act_stream_buffer #(
    parameter int NUM_BANKS = 8,
    parameter int ACT_BITS  = 16,
    parameter int DEPTH     = 256,
    parameter int AW        = $clog2(DEPTH),
    parameter int LW        = $clog2(NUM_BANKS) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [AW-1:0]                 wr_addr,
    input  logic [NUM_BANKS-1:0]          wr_mask,
    input  logic [NUM_BANKS*ACT_BITS-1:0] wr_data,
    input  logic                          swap_req,
    output logic                          swap_ack,
    input  logic [AW-1:0]                 cfg_base,
    input  logic [AW-1:0]                 cfg_stride,
    input  logic [AW:0]                   cfg_count,
    input  logic [LW-1:0]                 cfg_lanes,
    input  logic                          start,
    output logic                          busy,
    output logic [NUM_BANKS*ACT_BITS-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          done,
    output logic                          err_start,
    output logic [31:0]                   stall_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int W = NUM_BANKS * ACT_BITS;

    // Both bank sets live in one array; the top address bit selects the set.
    logic [W-1:0] mem [0:2*DEPTH-1];

    state_t               state;
    logic                 active_set;
    logic                 swap_pending;
    logic [AW-1:0]        ptr;
    logic [AW-1:0]        stride;
    logic [AW:0]          rem;
    logic [NUM_BANKS-1:0] lane_en;
    logic [NUM_BANKS-1:0] start_lanes;
    logic [W-1:0]         rd_row;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (wr_mask[b]) begin
                    mem[{~active_set, wr_addr}][b*ACT_BITS +: ACT_BITS] <= wr_data[b*ACT_BITS +: ACT_BITS];
                end
            end
        end
    end

    // A lane count of zero or beyond the bank count means every lane is live.
    always_comb begin
        start_lanes = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            start_lanes[b] = (cfg_lanes == '0) || (cfg_lanes > LW'(NUM_BANKS)) || (LW'(b) < cfg_lanes);
        end
    end

    always_comb begin
        rd_row = mem[{active_set, ptr}];
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (!lane_en[b]) begin
                rd_row[b*ACT_BITS +: ACT_BITS] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            active_set   <= 1'b0;
            swap_pending <= 1'b0;
            swap_ack     <= 1'b0;
            busy         <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            done         <= 1'b0;
            err_start    <= 1'b0;
            stall_count  <= '0;
            ptr          <= '0;
            stride       <= '0;
            rem          <= '0;
            lane_en      <= '0;
        end else begin
            swap_ack  <= 1'b0;
            done      <= 1'b0;
            err_start <= 1'b0;

            if (out_valid && !out_ready && stall_count != '1) begin
                stall_count <= stall_count + 32'd1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        ptr     <= cfg_base;
                        stride  <= cfg_stride;
                        rem     <= cfg_count;
                        lane_en <= start_lanes;
                        busy    <= 1'b1;
                        if (swap_req) begin
                            swap_pending <= 1'b1;
                        end
                        if (cfg_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end else if (swap_req) begin
                        active_set <= ~active_set;
                        swap_ack   <= 1'b1;
                    end
                end

                RUN: begin
                    if (start) begin
                        err_start <= 1'b1;
                    end
                    if (swap_req) begin
                        swap_pending <= 1'b1;
                    end
                    if (out_valid && out_ready && out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= DONE;
                        done      <= 1'b1;
                    end else if (rem != '0 && (!out_valid || out_ready)) begin
                        out_data  <= rd_row;
                        out_valid <= 1'b1;
                        out_last  <= (rem == (AW+1)'(1));
                        ptr       <= ptr + stride;
                        rem       <= rem - (AW+1)'(1);
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end

                DONE: begin
                    if (start) begin
                        err_start <= 1'b1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                    // Deferred swaps (and one arriving right now) land here, between streams.
                    if (swap_pending || swap_req) begin
                        active_set   <= ~active_set;
                        swap_ack     <= 1'b1;
                        swap_pending <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_act_stream_buffer.sv
// Directed bench for tpu_act_stream_buffer: a memory model predicts every streamed beat
// into a queue that a negedge monitor drains as the consumer accepts beats.
module tb_tpu_act_stream_buffer;

    localparam int NB    = 8;
    localparam int AB    = 16;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int LW    = 4;
    localparam int W     = NB * AB;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [NB-1:0] wr_mask;
    logic [W-1:0]  wr_data;
    logic          swap_req;
    logic          swap_ack;
    logic [AW-1:0] cfg_base;
    logic [AW-1:0] cfg_stride;
    logic [AW:0]   cfg_count;
    logic [LW-1:0] cfg_lanes;
    logic          start;
    logic          busy;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          done;
    logic          err_start;
    logic [31:0]   stall_count;

    always #5 clk = ~clk;

    tpu_act_stream_buffer dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
        .swap_req(swap_req), .swap_ack(swap_ack),
        .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_count(cfg_count), .cfg_lanes(cfg_lanes),
        .start(start), .busy(busy),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .done(done), .err_start(err_start), .stall_count(stall_count)
    );

    int checks   = 0;
    int failures = 0;

    logic [AB-1:0] model [0:1][0:DEPTH-1][0:NB-1];
    bit            tb_act;
    beat_t         exp_q[$];
    beat_t         mon_beat;

    int cyc       = 0;
    int beats     = 0;
    int first_cyc = -1;
    int last_cyc  = -1;
    int done_cyc  = -1;
    int done_cnt  = 0;

    task automatic check_output(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_row(bit set, int row, int lanes);
        logic [W-1:0] r;
        int eff;
        eff = (lanes == 0 || lanes > NB) ? NB : lanes;
        r = '0;
        for (int b = 0; b < NB; b++) begin
            if (b < eff) r[b*AB +: AB] = model[set][row][b];
        end
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Consumer-side monitor: every accepted beat must match the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                check_output("beat_expected", {127'd0, exp_q.size() != 0}, 1);
                if (exp_q.size() != 0) begin
                    mon_beat = exp_q.pop_front();
                    check_output("beat_data", out_data, mon_beat.data);
                    check_output("beat_last", {127'd0, out_last}, {127'd0, mon_beat.last});
                end
                if (first_cyc < 0) first_cyc = cyc;
                if (out_last) last_cyc = cyc;
                beats++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(int addr, logic [NB-1:0] mask, logic [W-1:0] data);
        bit shadow;
        shadow  = ~tb_act;
        wr_en   = 1'b1;
        wr_addr = addr[AW-1:0];
        wr_mask = mask;
        wr_data = data;
        for (int b = 0; b < NB; b++) begin
            if (mask[b]) model[shadow][addr][b] = data[b*AB +: AB];
        end
        step();
        wr_en = 1'b0;
    endtask

    task automatic swap_idle(string tag);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check_output(tag, {127'd0, swap_ack}, 1);
        tb_act = ~tb_act;
    endtask

    task automatic start_stream(int base, int stride, int count, int lanes);
        int    row;
        beat_t nb;
        row = base;
        for (int i = 0; i < count; i++) begin
            nb.data = exp_row(tb_act, row, lanes);
            nb.last = (i == count - 1);
            exp_q.push_back(nb);
            row = (row + stride) % DEPTH;
        end
        first_cyc  = -1;
        last_cyc   = -1;
        beats      = 0;
        cfg_base   = base[AW-1:0];
        cfg_stride = stride[AW-1:0];
        cfg_count  = count[AW:0];
        cfg_lanes  = lanes[LW-1:0];
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_done(string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (done === 1'b1) found = 1'b1;
        end
        check_output(tag, {127'd0, found}, 1);
    endtask

    task automatic wait_valid(string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (out_valid === 1'b1) found = 1'b1;
            else step();
        end
        check_output(tag, {127'd0, found}, 1);
    endtask

    initial begin
        logic [W-1:0] d;
        int done_base;
        int seen;
        int vseen;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
        swap_req = 1'b0; cfg_base = '0; cfg_stride = '0; cfg_count = '0; cfg_lanes = '0;
        start = 1'b0; out_ready = 1'b0; tb_act = 1'b0;
        step();
        step();
        check_output("rst_out_valid", {127'd0, out_valid}, 0);
        check_output("rst_busy", {127'd0, busy}, 0);
        check_output("rst_done", {127'd0, done}, 0);
        check_output("rst_swap_ack", {127'd0, swap_ack}, 0);
        check_output("rst_err_start", {127'd0, err_start}, 0);
        check_output("rst_out_last", {127'd0, out_last}, 0);
        check_output("rst_stall_count", {96'd0, stall_count}, 0);
        check_output("rst_out_data", out_data, 0);
        rst = 1'b0;
        step();

        // T1: load rows 0..3, swap, stream them back-to-back.
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < NB; b++) d[b*AB +: AB] = 16'(16 * r + b);
            write_row(r, 8'hFF, d);
        end
        swap_idle("t1_swap_ack");
        step();
        check_output("t1_swap_ack_pulse", {127'd0, swap_ack}, 0);
        out_ready = 1'b1;
        done_base = done_cnt;
        start_stream(0, 1, 4, 8);
        wait_done("t1_done_seen");
        step();
        check_output("t1_done_one_cycle", {127'd0, done}, 0);
        check_output("t1_done_count", done_cnt - done_base, 1);
        check_output("t1_beats", beats, 4);
        check_output("t1_back_to_back", last_cyc - first_cyc, 3);
        check_output("t1_done_after_last", done_cyc - last_cyc, 1);
        check_output("t1_queue_empty", exp_q.size(), 0);

        // T2: wrap-around stride with lane masking; row 4 gets a partial-mask overwrite.
        write_row(254, 8'hFF, {16'hA7FE, 16'hA6FE, 16'hA5FE, 16'hA4FE, 16'hA3FE, 16'hA2FE, 16'hA1FE, 16'hA0FE});
        write_row(1,   8'hFF, {16'hB701, 16'hB601, 16'hB501, 16'hB401, 16'hB301, 16'hB201, 16'hB101, 16'hB001});
        write_row(4,   8'hFF, {16'hC704, 16'hC604, 16'hC504, 16'hC404, 16'hC304, 16'hC204, 16'hC104, 16'hC004});
        write_row(4,   8'h0F, {16'h5507, 16'h5506, 16'h5505, 16'h5504, 16'h5503, 16'h5502, 16'h5501, 16'h5500});
        swap_idle("t2_swap_ack");
        start_stream(254, 3, 3, 5);
        wait_done("t2_done_seen");
        step();
        check_output("t2_beats", beats, 3);
        check_output("t2_queue_empty", exp_q.size(), 0);

        // T3: hold beat 2 for three stalled cycles.
        start_stream(254, 3, 3, 8);
        wait_valid("t3_first_valid");
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_output("t3_hold_valid", {127'd0, out_valid}, 1);
            check_output("t3_hold_data", out_data, exp_row(0, 1, 8));
            check_output("t3_hold_last", {127'd0, out_last}, 0);
        end
        check_output("t3_stall_count", {96'd0, stall_count}, 3);
        out_ready = 1'b1;
        wait_done("t3_done_seen");
        step();
        check_output("t3_beats", beats, 3);
        check_output("t3_queue_empty", exp_q.size(), 0);

        // T4: swap and start while busy; swap must wait for the DONE cycle.
        start_stream(254, 3, 3, 8);
        swap_req = 1'b1;
        start    = 1'b1;
        step();
        swap_req = 1'b0;
        start    = 1'b0;
        check_output("t4_err_start", {127'd0, err_start}, 1);
        step();
        check_output("t4_err_start_pulse", {127'd0, err_start}, 0);
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                check_output("t4_no_early_ack", {127'd0, swap_ack}, 0);
                if (done === 1'b1) found = 1'b1;
                else step();
            end
            check_output("t4_done_seen", {127'd0, found}, 1);
        end
        step();
        check_output("t4_swap_ack_after_done", {127'd0, swap_ack}, 1);
        check_output("t4_done_cleared", {127'd0, done}, 0);
        tb_act = ~tb_act;
        step();
        check_output("t4_swap_ack_pulse", {127'd0, swap_ack}, 0);
        check_output("t4_queue_empty", exp_q.size(), 0);

        // T5: empty stream, then a shadow write during a stream.
        seen  = 0;
        vseen = 0;
        start_stream(0, 1, 0, 8);
        for (int k = 0; k < 3; k++) begin
            if (done === 1'b1) seen++;
            if (out_valid === 1'b1) vseen++;
            step();
        end
        check_output("t5_zero_done_pulses", seen, 1);
        check_output("t5_zero_no_valid", vseen, 0);
        check_output("t5_zero_idle", {127'd0, busy}, 0);
        start_stream(0, 1, 4, 0);
        write_row(2, 8'hFF, {16'hBEE7, 16'hBEE6, 16'hBEE5, 16'hBEE4, 16'hBEE3, 16'hBEE2, 16'hBEE1, 16'hBEE0});
        wait_done("t5_done_seen");
        step();
        check_output("t5_queue_empty", exp_q.size(), 0);
        swap_idle("t5_swap_ack");
        start_stream(2, 1, 1, 8);
        wait_done("t5_reread_done");
        step();
        check_output("t5_reread_beats", beats, 1);
        check_output("t5_reread_empty", exp_q.size(), 0);

        // T6: reset in the middle of a stride-0 stream.
        start_stream(2, 0, 4, 8);
        wait_valid("t6_first_valid");
        step();
        rst = 1'b1;
        step();
        check_output("t6_rst_valid", {127'd0, out_valid}, 0);
        check_output("t6_rst_busy", {127'd0, busy}, 0);
        check_output("t6_rst_done", {127'd0, done}, 0);
        check_output("t6_rst_data", out_data, 0);
        check_output("t6_rst_stall", {96'd0, stall_count}, 0);
        rst = 1'b0;
        exp_q.delete();
        tb_act    = 1'b0;
        done_base = done_cnt;
        for (int k = 0; k < 4; k++) step();
        check_output("t6_no_done", done_cnt - done_base, 0);
        start_stream(2, 0, 2, 3);
        wait_done("t6_restart_done");
        step();
        check_output("t6_restart_beats", beats, 2);
        check_output("t6_restart_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
